demux_stream_1ton: RTL
======================

Name: demux_stream_1toN

Overview:
- Parametrised, registered 1-to-N stream demultiplexer with valid/ready handshakes on the input and on every output channel.
- Successor to the combinational 1-to-16 data demux. Adds:
  - one-entry holding register per channel
  - per-channel backpressure
  - broadcast mode
  - out-of-range select detection
- Sits between a single producer and N independent consumers in the data-routing path.

Parameters:
WIDTH, 8, data width in bits per channel
NCH, 16, number of output channels (2..64, need not be a power of two)
SEL_W, $clog2(NCH), select width (derived; do not override)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  WIDTH  input payload
in_sel  input  SEL_W  destination channel index
in_bcast  input  1  1 = send to all channels, in_sel ignored
in_valid  input  1  input payload valid
in_ready  output  1  block accepts input this cycle
out_data  output  NCH*WIDTH  flattened outputs; channel k occupies bits [k*WIDTH +: WIDTH]
out_valid  output  NCH  per-channel valid
out_ready  input  NCH  per-channel consumer ready
err_sel  output  1  one-cycle pulse: accepted unicast word had in_sel >= NCH

Behaviour:
- Interface timing: one clock; reset is asynchronous and active-low (rst_n); all other logic synchronous to clk.
- Reset values:
  - all holding-register valid bits = 0, so out_valid = 0
  - all holding data = 0
  - err_sel = 0
  - in_ready follows its combinational rule below. With all channels empty it is 1 during and after reset.
- Per-channel state: vld[k], dat[k].
  - out_valid[k] = vld[k].
  - out_data slice k = dat[k] when vld[k] = 1, else all-zero. No stale data is ever visible.
- Channel free condition: free[k] = !vld[k] || out_ready[k]. A draining register can be refilled in the same cycle.
- in_ready (combinational, no dependence on in_valid):
  - in_bcast = 1: AND of free[k] over all k
  - in_bcast = 0, in_sel < NCH: free[in_sel]
  - in_bcast = 0, in_sel >= NCH: 1 (the word is sunk)
- Accept condition: acc = in_valid && in_ready. The producer must hold data/sel/bcast stable while valid && !ready.
- Per-channel next state, channel k, each clock:
  - Load when acc && (in_bcast || in_sel == k): vld[k] <= 1, dat[k] <= in_data.
  - Otherwise, if vld[k] && out_ready[k]: vld[k] <= 0. dat[k] may hold or clear; the output is masked either way.
  - Otherwise: hold.
- err_sel <= acc && !in_bcast && (in_sel >= NCH). It is registered, high exactly one cycle after the accept. No channel is loaded for that word.
- Latency: accepted word appears on out_valid/out_data of its target one cycle after the accepting edge.
- Throughput: one word per cycle per channel when its consumer holds out_ready = 1. Words to different channels can be accepted on consecutive cycles regardless of other channels' stalls (no head-of-line blocking beyond the selected channel).
- Simultaneous events:
  - A drain and a load on the same channel in the same cycle produce a load: vld stays 1 with the new data.
  - Broadcast waits until every channel is free, then loads all NCH channels in one edge.
- Ordering: per channel, words emerge in acceptance order. No ordering is guaranteed across channels.
- Reset mid-operation: all pending held words are discarded immediately (asynchronously), and out_valid drops to 0 without waiting for a clock. Nothing is replayed after release.
- out_ready[k] asserted while vld[k] = 0 has no effect.

Test Plan:
1. Reset/idle: hold rst_n = 0, then release with in_valid = 0 → out_valid = 0, out_data = 0, err_sel = 0, in_ready = 1.
2. Unicast sweep (NCH = 16, WIDTH = 8, all out_ready = 1): send data 8'hA0+k with sel = k for k = 0..15 on consecutive cycles → channel k shows 8'hA0+k with out_valid[k] = 1 for exactly one cycle, one cycle after its accept. All other slices stay zero.
3. Backpressure:
   - Set out_ready[3] = 0 and send 8'h11 then 8'h22 to sel = 3 → first word accepted and held, then in_ready = 0 while the second is presented.
   - Meanwhile a word 8'h55 with sel = 4 is accepted → ch4 shows it next cycle.
   - Raise out_ready[3] → 8'h11 drains and 8'h22 loads on the same edge.
4. Broadcast: hold out_ready[7] = 0 with ch7 holding data, then present in_bcast = 1, data 8'h5A → in_ready = 0. Release out_ready[7] → next edge accepts, and all 16 channels show 8'h5A.
5. Out-of-range select (NCH = 10, SEL_W = 4): send sel = 12, data 8'hFF → in_ready = 1, no out_valid asserted, err_sel = 1 for exactly one cycle.
6. Reset mid-operation: fill channels 0, 5, 9 with out_ready = 0, then pulse rst_n low between clock edges → out_valid goes 0 immediately. After release all channels are empty, and a new word to ch5 appears after one cycle.

Source files
------------

// File: rtl/demux_stream_1ton.sv
// Registered 1-to-N stream demultiplexer: one holding register per channel,
// per-channel backpressure, broadcast, and out-of-range select detection.
module demux_stream_1ton #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 16,
  parameter int unsigned SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SEL_W-1:0]     in_sel,
  input  logic                 in_bcast,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic                 err_sel
);

  logic [NCH-1:0]   vld;
  logic [WIDTH-1:0] dat [NCH];

  logic [NCH-1:0] free_c;
  logic [NCH-1:0] hit_c;
  logic [NCH-1:0] load_c;
  logic           sel_oob_c;
  logic           acc_c;

  // Channel free/select decode, input handshake and per-channel load enables
  always_comb begin
    free_c    = '0;
    hit_c     = '0;
    load_c    = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      free_c[k] = !vld[k] || out_ready[k];
      hit_c[k]  = (32'(in_sel) == k);
    end
    sel_oob_c = (32'(in_sel) >= NCH);
    if (in_bcast) begin
      in_ready = &free_c;
    end else if (sel_oob_c) begin
      in_ready = 1'b1;
    end else begin
      in_ready = |(free_c & hit_c);
    end
    acc_c = in_valid && in_ready;
    if (acc_c) begin
      load_c = in_bcast ? {NCH{1'b1}} : hit_c;
    end
  end

  // Holding registers; data is cleared on drain so an empty slot always reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      err_sel <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        dat[k] <= '0;
      end
    end else begin
      err_sel <= acc_c && !in_bcast && sel_oob_c;
      for (int unsigned k = 0; k < NCH; k++) begin
        if (load_c[k]) begin
          vld[k] <= 1'b1;
          dat[k] <= in_data;
        end else if (vld[k] && out_ready[k]) begin
          vld[k] <= 1'b0;
          dat[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    out_valid = vld;
    out_data  = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      out_data[k*WIDTH +: WIDTH] = dat[k];
    end
  end

endmodule
